// File: rtl/demux_pkg.sv
// demux_pkg
// Shared constants and helpers for the 1-to-3 registered demultiplexer.
// Contents:
//   SEL_0 / SEL_1 / SEL_2  selector codes for the three output channels
//   SEL_INVALIDO           selector code for the invalid destination
//   NUM_CANAIS             number of output channels
//   DESCARTES_MAX          saturation value of the discard counter
//   incSaturado()          saturating increment used by the discard counter
package demux_pkg;

  localparam logic [1:0] SEL_0        = 2'b00;
  localparam logic [1:0] SEL_1        = 2'b01;
  localparam logic [1:0] SEL_2        = 2'b10;
  localparam logic [1:0] SEL_INVALIDO = 2'b11;

  localparam int NUM_CANAIS = 3;

  localparam logic [7:0] DESCARTES_MAX = 8'hFF;

  // Once the counter reaches its maximum it stays there instead of wrapping,
  // so a long burst of invalid words can never make it look small again.
  function automatic logic [7:0] incSaturado(input logic [7:0] valor);
    return (valor == DESCARTES_MAX) ? valor : valor + 8'd1;
  endfunction

endpackage

// File: rtl/buffer_saida.sv
// buffer_saida
// One-entry output buffer (data word plus valid flag) for a single
// demultiplexer channel, with a valid/ready handshake towards the consumer.
// Ports:
//   clk        clock, state updates on rising edge
//   rst_n      asynchronous active-low reset, clears data and valid
//   i_load     write i_data into the buffer on this edge
//   i_data     word to store
//   i_pronta   consumer takes the held word on this edge
//   o_data     held word
//   o_valida   buffer holds a word
//   o_livre    buffer can take a new word this cycle
module buffer_saida
  import demux_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pronta,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valida,
  output logic             o_livre
);

  logic [WIDTH-1:0] r_data;
  logic             r_valida;

  // The buffer can take a new word when it is empty, or when the word it
  // holds is leaving on this same edge. The second case is what lets a
  // channel sustain one word per cycle without a bubble.
  assign o_livre = !r_valida || i_pronta;

  // A load always wins over a drain: when both happen on the same edge the
  // old word leaves and the new one takes its place, so valid stays high.
  // Without a load, a drain empties the buffer; otherwise the contents hold
  // still so the consumer sees a stable word under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data   <= '0;
      r_valida <= 1'b0;
    end else if (i_load) begin
      r_data   <= i_data;
      r_valida <= 1'b1;
    end else if (r_valida && i_pronta) begin
      r_valida <= 1'b0;
    end
  end

  assign o_data   = r_data;
  assign o_valida = r_valida;

endmodule

// File: rtl/demux1_3_reg.sv
// demux1_3_reg
// Registered 1-to-3 demultiplexer with valid/ready handshakes on the input
// and on each output channel. Words with an invalid selector are accepted,
// discarded, flagged on erro for one cycle and counted in descartes.
// Ports:
//   clk, rst_n                      clock and asynchronous active-low reset
//   seletor                         destination of the current input word
//   entrada, entrada_valida         input word and its valid flag
//   entrada_pronta                  block can accept the input word this cycle
//   saidaN, saidaN_valida           registered word and valid flag, channel N
//   saidaN_pronta                   consumer of channel N takes the word
//   erro                            pulse one cycle after an invalid transfer
//   descartes                       saturating count of invalid transfers
module demux1_3_reg
  import demux_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       seletor,
  input  logic [WIDTH-1:0] entrada,
  input  logic             entrada_valida,
  output logic             entrada_pronta,
  output logic [WIDTH-1:0] saida0,
  output logic [WIDTH-1:0] saida1,
  output logic [WIDTH-1:0] saida2,
  output logic             saida0_valida,
  output logic             saida1_valida,
  output logic             saida2_valida,
  input  logic             saida0_pronta,
  input  logic             saida1_pronta,
  input  logic             saida2_pronta,
  output logic             erro,
  output logic [7:0]       descartes
);

  logic [NUM_CANAIS-1:0] w_carga;
  logic [NUM_CANAIS-1:0] w_livre;
  logic [NUM_CANAIS-1:0] w_valida;
  logic [NUM_CANAIS-1:0] w_pronta;
  logic [WIDTH-1:0]      w_dados [NUM_CANAIS];
  logic                  w_transfer;
  logic                  w_invalido;

  logic                  r_erro;
  logic [7:0]            r_descartes;

  assign w_pronta = {saida2_pronta, saida1_pronta, saida0_pronta};

  // Input readiness follows the selected channel only. An invalid selector
  // is always ready because the word is simply dropped, so a bad producer
  // can never stall the input.
  always_comb begin
    entrada_pronta = 1'b1;
    case (seletor)
      SEL_0:   entrada_pronta = w_livre[0];
      SEL_1:   entrada_pronta = w_livre[1];
      SEL_2:   entrada_pronta = w_livre[2];
      default: entrada_pronta = 1'b1;
    endcase
  end

  assign w_transfer = entrada_valida && entrada_pronta;
  assign w_invalido = w_transfer && (seletor == SEL_INVALIDO);

  // Only the selected channel is loaded on an accepted transfer; the other
  // two buffers keep draining on their own handshakes.
  always_comb begin
    w_carga    = '0;
    w_carga[0] = w_transfer && (seletor == SEL_0);
    w_carga[1] = w_transfer && (seletor == SEL_1);
    w_carga[2] = w_transfer && (seletor == SEL_2);
  end

  for (genvar g = 0; g < NUM_CANAIS; g++) begin : g_canal
    buffer_saida #(
      .WIDTH (WIDTH)
    ) u_buffer (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_load   (w_carga[g]),
      .i_data   (entrada),
      .i_pronta (w_pronta[g]),
      .o_data   (w_dados[g]),
      .o_valida (w_valida[g]),
      .o_livre  (w_livre[g])
    );
  end

  // erro is registered straight from the invalid-transfer condition, so it
  // is high for exactly the cycle after each discarded word. The discard
  // counter sticks at its maximum while erro keeps pulsing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_erro      <= 1'b0;
      r_descartes <= '0;
    end else begin
      r_erro <= w_invalido;
      if (w_invalido) begin
        r_descartes <= incSaturado(r_descartes);
      end
    end
  end

  assign erro          = r_erro;
  assign descartes     = r_descartes;
  assign saida0        = w_dados[0];
  assign saida1        = w_dados[1];
  assign saida2        = w_dados[2];
  assign saida0_valida = w_valida[0];
  assign saida1_valida = w_valida[1];
  assign saida2_valida = w_valida[2];

endmodule

// File: tb/tb_demux1_3_reg.sv
// tb_demux1_3_reg
// Self-checking bench for demux1_3_reg: directed scenarios followed by a
// randomized run compared against a queue-based reference model.
module tb_demux1_3_reg;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst_n;
  logic [1:0]       seletor;
  logic [WIDTH-1:0] entrada;
  logic             entrada_valida;
  logic             entrada_pronta;
  logic [WIDTH-1:0] saida0, saida1, saida2;
  logic             saida0_valida, saida1_valida, saida2_valida;
  logic             saida0_pronta, saida1_pronta, saida2_pronta;
  logic             erro;
  logic [7:0]       descartes;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] q0[$];
  logic [WIDTH-1:0] q1[$];
  logic [WIDTH-1:0] q2[$];

  demux1_3_reg #(
    .WIDTH (WIDTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .seletor        (seletor),
    .entrada        (entrada),
    .entrada_valida (entrada_valida),
    .entrada_pronta (entrada_pronta),
    .saida0         (saida0),
    .saida1         (saida1),
    .saida2         (saida2),
    .saida0_valida  (saida0_valida),
    .saida1_valida  (saida1_valida),
    .saida2_valida  (saida2_valida),
    .saida0_pronta  (saida0_pronta),
    .saida1_pronta  (saida1_pronta),
    .saida2_pronta  (saida2_pronta),
    .erro           (erro),
    .descartes      (descartes)
  );

  // Free-running 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge, where outputs are sampled
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Quiet all inputs and pulse reset away from the clock edge
  task automatic doReset();
    entrada_valida = 1'b0;
    seletor        = 2'b00;
    entrada        = '0;
    saida0_pronta  = 1'b0;
    saida1_pronta  = 1'b0;
    saida2_pronta  = 1'b0;
    rst_n          = 1'b0;
    tick();
    tick();
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  function automatic int qSize(int n);
    case (n)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] qFront(int n);
    case (n)
      0: return q0[0];
      1: return q1[0];
      default: return q2[0];
    endcase
  endfunction

  function automatic logic actValida(int n);
    case (n)
      0: return saida0_valida;
      1: return saida1_valida;
      default: return saida2_valida;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] actData(int n);
    case (n)
      0: return saida0;
      1: return saida1;
      default: return saida2;
    endcase
  endfunction

  // All outputs cleared after reset
  task automatic test_reset();
    doReset();
    checks++;
    if ({saida0_valida, saida1_valida, saida2_valida} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_valida: got %b expected 000", {saida0_valida, saida1_valida, saida2_valida});
    end
    checks++;
    if ({saida0, saida1, saida2} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_dados: got %h %h %h expected zeros", saida0, saida1, saida2);
    end
    checks++;
    if (erro !== 1'b0 || descartes !== 8'd0) begin
      errors++;
      $display("[TB] FAIL reset_erro: got erro=%b descartes=%0d expected 0/0", erro, descartes);
    end
  endtask

  // One word to channel 1 appears the following cycle on that channel only
  task automatic test_single_word();
    doReset();
    seletor        = 2'b01;
    entrada        = 32'hDEADBEEF;
    entrada_valida = 1'b1;
    tick();
    entrada_valida = 1'b0;
    checks++;
    if (saida1 !== 32'hDEADBEEF || saida1_valida !== 1'b1) begin
      errors++;
      $display("[TB] FAIL single_saida1: got %h/%b expected deadbeef/1", saida1, saida1_valida);
    end
    checks++;
    if (saida0_valida !== 1'b0 || saida2_valida !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_outros: got %b%b expected 00", saida0_valida, saida2_valida);
    end
  endtask

  // Backpressure on channel 2 blocks the second word until the first drains
  task automatic test_backpressure();
    doReset();
    seletor        = 2'b10;
    entrada        = 32'h1;
    entrada_valida = 1'b1;
    #1;
    checks++;
    if (entrada_pronta !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_primeiro_pronta: got %b expected 1", entrada_pronta);
    end
    tick();
    entrada = 32'h2;
    #1;
    checks++;
    if (entrada_pronta !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_segundo_bloqueado: got %b expected 0", entrada_pronta);
    end
    tick();
    checks++;
    if (saida2 !== 32'h1 || saida2_valida !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_estavel: got %h/%b expected 1/1", saida2, saida2_valida);
    end
    saida2_pronta = 1'b1;
    #1;
    checks++;
    if (entrada_pronta !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_liberado: got %b expected 1", entrada_pronta);
    end
    tick();
    entrada_valida = 1'b0;
    checks++;
    if (saida2 !== 32'h2 || saida2_valida !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_segunda_palavra: got %h/%b expected 2/1", saida2, saida2_valida);
    end
    tick();
    checks++;
    if (saida2_valida !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_esvaziado: got %b expected 0", saida2_valida);
    end
  endtask

  // Eight back-to-back words through channel 0 at one word per cycle
  task automatic test_back_to_back();
    doReset();
    saida0_pronta = 1'b1;
    for (int i = 0; i < 8; i++) begin
      seletor        = 2'b00;
      entrada        = WIDTH'(i);
      entrada_valida = 1'b1;
      #1;
      checks++;
      if (entrada_pronta !== 1'b1) begin
        errors++;
        $display("[TB] FAIL b2b_pronta[%0d]: got %b expected 1", i, entrada_pronta);
      end
      tick();
      checks++;
      if (saida0 !== WIDTH'(i) || saida0_valida !== 1'b1) begin
        errors++;
        $display("[TB] FAIL b2b_saida0[%0d]: got %h/%b expected %h/1", i, saida0, saida0_valida, WIDTH'(i));
      end
    end
    entrada_valida = 1'b0;
    tick();
    checks++;
    if (saida0_valida !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_fim: got %b expected 0", saida0_valida);
    end
  endtask

  // 260 invalid-selector words: erro every cycle, counter saturates at 255
  task automatic test_invalid();
    int expDesc;
    doReset();
    for (int i = 0; i < 260; i++) begin
      seletor        = 2'b11;
      entrada        = $urandom;
      entrada_valida = 1'b1;
      #1;
      checks++;
      if (entrada_pronta !== 1'b1) begin
        errors++;
        $display("[TB] FAIL inv_pronta[%0d]: got %b expected 1", i, entrada_pronta);
      end
      tick();
      expDesc = (i + 1 > 255) ? 255 : i + 1;
      checks++;
      if (erro !== 1'b1 || descartes !== 8'(expDesc)) begin
        errors++;
        $display("[TB] FAIL inv_contagem[%0d]: got erro=%b descartes=%0d expected 1/%0d", i, erro, descartes, expDesc);
      end
      checks++;
      if ({saida0_valida, saida1_valida, saida2_valida} !== 3'b000) begin
        errors++;
        $display("[TB] FAIL inv_valida[%0d]: got %b expected 000", i, {saida0_valida, saida1_valida, saida2_valida});
      end
    end
    entrada_valida = 1'b0;
    tick();
    checks++;
    if (erro !== 1'b0 || descartes !== 8'd255) begin
      errors++;
      $display("[TB] FAIL inv_fim: got erro=%b descartes=%0d expected 0/255", erro, descartes);
    end
  endtask

  // Channel 1 stalled with a word while channel 0 streams independently
  task automatic test_independent();
    logic [WIDTH-1:0] w;
    doReset();
    seletor        = 2'b01;
    entrada        = 32'hA5A5A5A5;
    entrada_valida = 1'b1;
    tick();
    #1;
    checks++;
    if (entrada_pronta !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ind_canal1_cheio: got %b expected 0", entrada_pronta);
    end
    saida0_pronta = 1'b1;
    for (int i = 0; i < 10; i++) begin
      w       = $urandom;
      seletor = 2'b00;
      entrada = w;
      #1;
      checks++;
      if (entrada_pronta !== 1'b1) begin
        errors++;
        $display("[TB] FAIL ind_pronta[%0d]: got %b expected 1", i, entrada_pronta);
      end
      tick();
      checks++;
      if (saida0 !== w || saida0_valida !== 1'b1) begin
        errors++;
        $display("[TB] FAIL ind_saida0[%0d]: got %h/%b expected %h/1", i, saida0, saida0_valida, w);
      end
      checks++;
      if (saida1 !== 32'hA5A5A5A5 || saida1_valida !== 1'b1) begin
        errors++;
        $display("[TB] FAIL ind_saida1[%0d]: got %h/%b expected a5a5a5a5/1", i, saida1, saida1_valida);
      end
    end
    entrada_valida = 1'b0;
  endtask

  // Asynchronous reset mid-cycle with all channels full, then recovery
  task automatic test_async_reset();
    doReset();
    entrada_valida = 1'b1;
    for (int n = 0; n < 4; n++) begin
      seletor = 2'(n);
      entrada = 32'h100 + WIDTH'(n);
      tick();
    end
    entrada_valida = 1'b0;
    checks++;
    if ({saida0_valida, saida1_valida, saida2_valida, erro} !== 4'b1111 || descartes !== 8'd1) begin
      errors++;
      $display("[TB] FAIL ar_preparo: got %b%b%b erro=%b descartes=%0d expected 111/1/1",
               saida0_valida, saida1_valida, saida2_valida, erro, descartes);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({saida0_valida, saida1_valida, saida2_valida, erro} !== 4'b0000 || descartes !== 8'd0) begin
      errors++;
      $display("[TB] FAIL ar_imediato: got %b%b%b erro=%b descartes=%0d expected 000/0/0",
               saida0_valida, saida1_valida, saida2_valida, erro, descartes);
    end
    checks++;
    if ({saida0, saida1, saida2} !== '0) begin
      errors++;
      $display("[TB] FAIL ar_dados: got %h %h %h expected zeros", saida0, saida1, saida2);
    end
    seletor        = 2'b00;
    entrada        = 32'h55;
    entrada_valida = 1'b1;
    tick();
    checks++;
    if (saida0_valida !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ar_sem_transfer: got %b expected 0", saida0_valida);
    end
    #2;
    rst_n = 1'b1;
    tick();
    entrada_valida = 1'b0;
    checks++;
    if (saida0 !== 32'h55 || saida0_valida !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ar_retomada: got %h/%b expected 55/1", saida0, saida0_valida);
    end
  endtask

  // Random traffic against a per-channel queue model of the handshake rules
  task automatic test_random();
    logic [1:0]       sel;
    logic             val;
    logic [2:0]       pr;
    logic [WIDTH-1:0] dat;
    logic             expPronta;
    logic             expErro;
    int               expDesc;
    doReset();
    q0.delete();
    q1.delete();
    q2.delete();
    expDesc = 0;
    for (int c = 0; c < 600; c++) begin
      sel = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      val = ($urandom_range(0, 3) != 0);
      pr  = 3'($urandom);
      dat = $urandom;
      seletor        = sel;
      entrada        = dat;
      entrada_valida = val;
      saida0_pronta  = pr[0];
      saida1_pronta  = pr[1];
      saida2_pronta  = pr[2];
      expPronta = (sel == 2'b11) ? 1'b1 : (qSize(int'(sel)) == 0 || pr[sel]);
      #1;
      checks++;
      if (entrada_pronta !== expPronta) begin
        errors++;
        $display("[TB] FAIL rnd_pronta[%0d]: got %b expected %b", c, entrada_pronta, expPronta);
      end
      if (pr[0] && q0.size() > 0) void'(q0.pop_front());
      if (pr[1] && q1.size() > 0) void'(q1.pop_front());
      if (pr[2] && q2.size() > 0) void'(q2.pop_front());
      expErro = 1'b0;
      if (val && expPronta) begin
        case (sel)
          2'b00:   q0.push_back(dat);
          2'b01:   q1.push_back(dat);
          2'b10:   q2.push_back(dat);
          default: begin
            expErro = 1'b1;
            if (expDesc < 255) expDesc++;
          end
        endcase
      end
      tick();
      for (int n = 0; n < 3; n++) begin
        checks++;
        if (actValida(n) !== (qSize(n) > 0)) begin
          errors++;
          $display("[TB] FAIL rnd_valida%0d[%0d]: got %b expected %b", n, c, actValida(n), qSize(n) > 0);
        end else if (qSize(n) > 0 && actData(n) !== qFront(n)) begin
          errors++;
          $display("[TB] FAIL rnd_saida%0d[%0d]: got %h expected %h", n, c, actData(n), qFront(n));
        end
      end
      checks++;
      if (erro !== expErro || descartes !== 8'(expDesc)) begin
        errors++;
        $display("[TB] FAIL rnd_erro[%0d]: got %b/%0d expected %b/%0d", c, erro, descartes, expErro, expDesc);
      end
    end
    entrada_valida = 1'b0;
  endtask

  // Scenario sequence and summary
  initial begin
    rst_n          = 1'b0;
    seletor        = 2'b00;
    entrada        = '0;
    entrada_valida = 1'b0;
    saida0_pronta  = 1'b0;
    saida1_pronta  = 1'b0;
    saida2_pronta  = 1'b0;
    test_reset();
    test_single_word();
    test_backpressure();
    test_back_to_back();
    test_invalid();
    test_independent();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux1_3_reg.md
DEMUX1_3_REG -- requirements
Module: demux1_3_reg

Interface
REQ-001 SHALL have parameter: WIDTH, default 32, data bus width in bits.
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: seletor  input  2  destination of the current input word (00->0, 01->1, 10->2, 11 invalid).
REQ-005 SHALL have port: entrada  input  WIDTH  input data word.
REQ-006 SHALL have port: entrada_valida  input  1  input word present.
REQ-007 SHALL have port: entrada_pronta  output  1  block can accept the input word this cycle.
REQ-008 SHALL have ports: saida0/saida1/saida2  output  WIDTH each  registered output data per channel.
REQ-009 SHALL have ports: saida0_valida/saida1_valida/saida2_valida  output  1 each  channel holds a word.
REQ-010 SHALL have ports: saida0_pronta/saida1_pronta/saida2_pronta  input  1 each  consumer takes the word this cycle.
REQ-011 SHALL have port: erro  output  1  one-cycle pulse after an invalid-selector transfer.
REQ-012 SHALL have port: descartes  output  8  saturating count of invalid-selector transfers.

Function
REQ-013 SHALL define input transfer as entrada_valida && entrada_pronta on a rising clk edge.
REQ-014 SHALL define channel N transfer as saidaN_valida && saidaN_pronta on a rising clk edge.
REQ-015 SHALL hold one-entry buffer per channel (data + valid flag); no other storage for data.
REQ-016 SHALL drive entrada_pronta combinationally: seletor=11 -> 1; else selected channel (!saidaN_valida || saidaN_pronta).
REQ-017 SHALL load an accepted word into the selected channel buffer: latency exactly 1 cycle, saidaN_valida=1 the following cycle.
REQ-018 SHALL clear saidaN_valida after a channel N transfer unless the same edge loads a new word into channel N.
REQ-019 SHALL on simultaneous channel N drain and load keep saidaN_valida=1 with new data: sustained 1 word/cycle per channel.
REQ-020 SHALL keep saidaN and saidaN_valida stable while saidaN_valida=1 and saidaN_pronta=0.
REQ-021 SHALL leave non-selected channel buffers unaffected by input transfers; they drain independently.
REQ-022 SHALL on accepted seletor=11 discard the word, pulse erro=1 for exactly the next cycle, increment descartes.
REQ-023 SHALL saturate descartes at 255; further invalid transfers still pulse erro.
REQ-024 SHALL ignore seletor and entrada when entrada_valida=0; no state change.
REQ-025 SHALL not reorder words per channel: channel output order equals acceptance order.

Reset
REQ-026 SHALL on rst_n=0 asynchronously clear all saidaN_valida, saidaN, erro and descartes to 0.
REQ-027 SHALL drop buffered words on reset mid-operation; no transfer completes while rst_n=0.
REQ-028 SHALL resume normal operation on the first rising clk edge after rst_n deasserts.

Structure
REQ-029 SHALL place selector constants SEL_0=00, SEL_1=01, SEL_2=10, SEL_INVALIDO=11 in shared package demux_pkg.
REQ-030 SHALL implement each channel buffer as sub-module buffer_saida (parameter WIDTH), instantiated three times.
REQ-031 SHALL keep the erro/descartes logic in the top module.

Verification
REQ-032 SHALL check: reset, then seletor=01, entrada=0xDEADBEEF, valida=1 one cycle -> next cycle saida1=0xDEADBEEF, saida1_valida=1, others valida=0.
REQ-033 SHALL check: saida2_pronta=0, two words 0x1, 0x2 to seletor=10 -> first accepted, entrada_pronta=0 for second; after saida2_pronta=1 outputs 0x1 then 0x2.
REQ-034 SHALL check: saida0_pronta=1 constant, 8 back-to-back words 0..7 to seletor=00 -> entrada_pronta=1 every cycle, saida0 yields 0..7 on consecutive cycles.
REQ-035 SHALL check: seletor=11 with valida=1 for 260 cycles -> entrada_pronta=1, erro pulses each following cycle, descartes ends at 255, no saidaN_valida asserted.
REQ-036 SHALL check: channel 1 full with saida1_pronta=0 while channel 0 traffic flows -> channel 0 words pass at 1/cycle, saida1 unchanged.
REQ-037 SHALL check: rst_n=0 asserted mid-cycle with all three channels valid -> all valida, erro, descartes 0 immediately, before next clk edge.
